// File: rtl/q_8_41_interpolator_if.sv
// Valid/ready bus for the pair-word interpolator: word input side, sample output side.
interface q_8_41_interpolator_if #(
   parameter int unsigned W = 8
) ();
   logic              en;
   logic              in_valid;
   logic [2*W-1:0]    in_data;
   logic              in_ready;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic              out_phase;
   logic              out_ready;

   // Interpolator side
   modport slave (
      input  en, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_phase
   );

   // Producer/sink side
   modport master (
      output en, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_phase
   );
endinterface

// File: rtl/q_8_41_interpolator.sv
// Pair-word interpolator: each 2W-bit word is emitted as two W-bit samples,
// upper (older) half first. One holding word R0 feeds a two-sample stage P1/P0.
// Optional feature macro: Q_8_41_INTERP_UNDERRUN_EN adds o_underrun_cnt.
module q_8_41_interpolator #(
   parameter int unsigned W = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   q_8_41_interpolator_if.slave      io_bus
`ifdef Q_8_41_INTERP_UNDERRUN_EN
   ,
   output logic [7:0]                o_underrun_cnt
`endif
);
   localparam int unsigned WW = 2 * W;

   typedef enum logic [1:0] {
      S_EMPTY  = 2'd0,
      S_FIRST  = 2'd1,
      S_SECOND = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [WW-1:0]   r_r0;
   logic            r_valid;
   logic [W-1:0]    r_p1;
   logic [W-1:0]    r_p0;

   logic            w_load;
   logic            w_accept;
   logic            w_in_ready;
   logic            w_out_valid;
   logic            w_out_phase;
   logic [W-1:0]    w_out_data;

   // R0 can only be written while empty, so accept and transfer never collide
   assign w_in_ready = !rst && io_bus.en && !r_valid;
   assign w_accept   = io_bus.in_valid && w_in_ready;

   // Next-state and output decode from registered state only
   always_comb begin
      w_state_nxt = S_EMPTY;
      w_load      = 1'b0;
      w_out_valid = 1'b0;
      w_out_phase = 1'b0;
      w_out_data  = '0;
      case (r_state)
         S_EMPTY: begin
            if (r_valid) begin
               w_load      = 1'b1;
               w_state_nxt = S_FIRST;
            end else begin
               w_state_nxt = S_EMPTY;
            end
         end
         S_FIRST: begin
            w_out_valid = 1'b1;
            w_out_data  = r_p1;
            w_state_nxt = io_bus.out_ready ? S_SECOND : S_FIRST;
         end
         S_SECOND: begin
            w_out_valid = 1'b1;
            w_out_phase = 1'b1;
            w_out_data  = r_p0;
            if (io_bus.out_ready) begin
               if (r_valid) begin
                  w_load      = 1'b1;
                  w_state_nxt = S_FIRST;
               end else begin
                  w_state_nxt = S_EMPTY;
               end
            end else begin
               w_state_nxt = S_SECOND;
            end
         end
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   // Outputs forced idle during the reset cycle, even mid-pair
   assign io_bus.in_ready  = w_in_ready;
   assign io_bus.out_valid = !rst && w_out_valid;
   assign io_bus.out_phase = !rst && w_out_phase;
   assign io_bus.out_data  = rst ? '0 : w_out_data;

   // State, holding register and output stage
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_EMPTY;
         r_r0    <= '0;
         r_valid <= 1'b0;
         r_p1    <= '0;
         r_p0    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_r0    <= io_bus.in_data;
            r_valid <= 1'b1;
         end else if (w_load) begin
            r_valid <= 1'b0;
         end
         if (w_load) begin
            r_p1 <= r_r0[WW-1:W];
            r_p0 <= r_r0[W-1:0];
         end
      end
   end

`ifdef Q_8_41_INTERP_UNDERRUN_EN
   logic [7:0] r_underrun_cnt;

   // Saturating count of cycles where the sink was ready but no sample was available
   always_ff @(posedge clk) begin
      if (rst) begin
         r_underrun_cnt <= 8'd0;
      end else if (io_bus.en && io_bus.out_ready && !w_out_valid && (r_underrun_cnt != 8'hFF)) begin
         r_underrun_cnt <= r_underrun_cnt + 8'd1;
      end
   end

   assign o_underrun_cnt = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_q_8_41_interpolator.sv
// Self-checking bench for q_8_41_interpolator: vector table plus scoreboard.
module tb_q_8_41_interpolator;
   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   q_8_41_interpolator_if #(.W(W)) bus ();
`ifdef Q_8_41_INTERP_UNDERRUN_EN
   logic [7:0] underrun_cnt;
`endif

   q_8_41_interpolator #(.W(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
`ifdef Q_8_41_INTERP_UNDERRUN_EN
      ,
      .o_underrun_cnt (underrun_cnt)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;
   logic [W:0] sb_q[$];

   typedef struct {
      logic [2*W-1:0] word;
      logic [W-1:0]   hi;
      logic [W-1:0]   lo;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Scoreboard: push both halves on input handshake, pop on output handshake
   always @(negedge clk) begin
      logic [W:0] exp_s;
      if (rst) begin
         sb_q.delete();
      end else begin
         if (bus.in_valid && bus.in_ready) begin
            sb_q.push_back({1'b0, bus.in_data[2*W-1:W]});
            sb_q.push_back({1'b1, bus.in_data[W-1:0]});
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb_unexpected: got data=%h phase=%0d, required no output (t=%0t)",
                        bus.out_data, bus.out_phase, $time);
            end else begin
               exp_s = sb_q.pop_front();
               chk("sb_sample", 32'({bus.out_phase, bus.out_data}), 32'(exp_s));
            end
         end
      end
   end

   initial begin
      vec_t           vecs[4];
      logic [2*W-1:0] sw[3];
      int idx, first_c, last_c, n_out;

      vecs[0] = '{16'h1234, 8'h12, 8'h34};
      vecs[1] = '{16'h00FF, 8'h00, 8'hFF};
      vecs[2] = '{16'hFF00, 8'hFF, 8'h00};
      vecs[3] = '{16'h8001, 8'h80, 8'h01};
      sw[0] = 16'h0102;
      sw[1] = 16'h0304;
      sw[2] = 16'h0506;

      rst           = 1'b1;
      bus.en        = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;

      // Reset state
      smp();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_out_phase", 32'(bus.out_phase), 32'd0);
      step();
      step();
      rst = 1'b0;
      smp();
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
`ifdef Q_8_41_INTERP_UNDERRUN_EN
      chk("post_rst_underrun", 32'(underrun_cnt), 32'd0);
`endif

      // Single words with exact latency
      for (int i = 0; i < 4; i++) begin
         step();
         bus.in_valid = 1'b1;
         bus.in_data  = vecs[i].word;
         smp();
         chk("vec_in_ready", 32'(bus.in_ready), 32'd1);
         step();
         bus.in_valid = 1'b0;
         smp();
         chk("vec_c1_valid", 32'(bus.out_valid), 32'd0);
         step();
         smp();
         chk("vec_c2_valid", 32'(bus.out_valid), 32'd1);
         chk("vec_c2_data", 32'(bus.out_data), 32'(vecs[i].hi));
         chk("vec_c2_phase", 32'(bus.out_phase), 32'd0);
         step();
         smp();
         chk("vec_c3_valid", 32'(bus.out_valid), 32'd1);
         chk("vec_c3_data", 32'(bus.out_data), 32'(vecs[i].lo));
         chk("vec_c3_phase", 32'(bus.out_phase), 32'd1);
         step();
         smp();
         chk("vec_c4_valid", 32'(bus.out_valid), 32'd0);
      end

      // Streaming three words
      idx = 0; first_c = -1; last_c = -1; n_out = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         bus.in_valid = (idx < 3);
         bus.in_data  = (idx < 3) ? sw[idx] : '0;
         smp();
         if (c < 6) chk("stream_in_ready", 32'(bus.in_ready), 32'((c % 2) == 0));
         if (bus.in_valid && bus.in_ready) idx++;
         if (bus.out_valid) begin
            if (first_c < 0) first_c = c;
            last_c = c;
            n_out++;
         end
      end
      chk("stream_first", 32'(first_c), 32'd2);
      chk("stream_last", 32'(last_c), 32'd7);
      chk("stream_count", 32'(n_out), 32'd6);

      // Backpressure: BEEF held in S_FIRST, second word latched meanwhile
      step();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'hBEEF;
      smp();
      chk("bp_c0_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      bus.in_data = 16'hC0DE;
      smp();
      chk("bp_c1_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      smp();
      chk("bp_c2_in_ready", 32'(bus.in_ready), 32'd1);
      for (int c = 2; c < 7; c++) begin
         if (c > 2) begin
            step();
            smp();
            chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
         end
         chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_hold_data", 32'(bus.out_data), 32'hBE);
         chk("bp_hold_phase", 32'(bus.out_phase), 32'd0);
      end
      step();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 6; c++) step();
      smp();
      chk("bp_drained", 32'(sb_q.size()), 32'd0);

      // en gating
      step();
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h7788;
      smp();
      chk("en_accept", 32'(bus.in_ready), 32'd1);
      n_out = 0;
      for (int c = 1; c < 9; c++) begin
         step();
         bus.en      = 1'b0;
         bus.in_data = 16'h9999;
         smp();
         chk("en_blocked_in_ready", 32'(bus.in_ready), 32'd0);
         if (bus.out_valid) n_out++;
      end
      chk("en_drain_count", 32'(n_out), 32'd2);
      step();
      bus.en = 1'b1;
      smp();
      chk("en_reenable_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
      for (int c = 0; c < 5; c++) step();
      smp();
      chk("en_drained", 32'(sb_q.size()), 32'd0);

      // Reset mid-pair: lower half must never appear
      step();
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hA55A;
      smp();
      step();
      bus.in_valid = 1'b0;
      smp();
      step();
      smp();
      chk("mid_upper_data", 32'(bus.out_data), 32'hA5);
      step();
      rst = 1'b1;
      smp();
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         smp();
         chk("mid_post_out_valid", 32'(bus.out_valid), 32'd0);
         step();
      end

`ifdef Q_8_41_INTERP_UNDERRUN_EN
      // Underrun saturation
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 300; c++) step();
      smp();
      chk("underrun_sat", 32'(underrun_cnt), 32'd255);
      for (int c = 0; c < 5; c++) step();
      smp();
      chk("underrun_hold", 32'(underrun_cnt), 32'd255);
`endif

      chk("sb_final_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/q_8_41_interpolator.md
# q_8_41_interpolator

Expands the 2·W-bit pair words produced by the decimator path back into a W-bit sample stream: each accepted word is emitted as two consecutive samples, the upper (older) half first, then the lower (newer) half. The block holds one word in a holding register R0 plus a two-sample output stage P1/P0 sequenced by a 3-state controller. Handshakes are valid/ready on both sides. With back-to-back input words and an always-ready sink, throughput is one sample per clock.

## Interface
- W, 8, sample width; input word width is 2·W
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- en  input  1  accept enable; 0 blocks new input words, words already held still drain
- in_valid  input  1  in_data valid
- in_data  input  2W  pair word {older sample, newer sample}
- in_ready  output  1  block can take a word this cycle
- out_valid  output  1  out_data holds a sample
- out_data  output  W  current sample
- out_phase  output  1  0 = upper half, 1 = lower half
- out_ready  input  1  sink takes the sample this cycle
- underrun_cnt  output  8  only with Q_8_41_INTERP_UNDERRUN_EN; see Configuration

## Operation
- Holding register: R0 (2W bits), r_valid flag. in_ready = en && !r_valid. On in_valid && in_ready: R0 <= in_data, r_valid <= 1.
- Output stage: P1, P0 (W bits each) and controller state.
- S_EMPTY: out_valid=0, out_data=0, out_phase=0. If r_valid: P1 <= R0[2W-1:W], P0 <= R0[W-1:0], r_valid <= 0, go to S_FIRST.
- S_FIRST: out_valid=1, out_data=P1, out_phase=0. If out_ready, go to S_SECOND. Otherwise hold.
- S_SECOND: out_valid=1, out_data=P0, out_phase=1. If out_ready and r_valid, reload P1/P0 from R0, clear r_valid, and go to S_FIRST. If out_ready and !r_valid, go to S_EMPTY. Otherwise hold.
- Unused state encoding: next state is S_EMPTY, all outputs as in S_EMPTY.
- An accept into R0 and a transfer out of R0 cannot happen in the same cycle, because in_ready requires !r_valid.
- en deasserted: no new words are accepted. A word already in R0 or P1/P0 still completes both samples.
- rst: state S_EMPTY, r_valid=0, R0/P1/P0=0, underrun_cnt=0. It takes precedence over every other event, including mid-pair; a half-emitted word is discarded.
- Outputs in reset: in_ready=0 (during the rst cycle), out_valid=0, out_data=0, out_phase=0.

## Timing
- Latency: if an input handshake occurs in cycle k, R0 is valid in cycle k+1, and the upper sample is presented (out_valid=1) in cycle k+2.
- Lower sample: presented in the cycle after the upper-sample handshake.
- Sustained rate: with continuous in_valid, en=1 and out_ready=1, out_valid stays high every cycle after the first word's latency.
  - in_ready pulses high every other cycle.
- Backpressure: out_data and out_phase are stable while out_valid && !out_ready. R0 holds at most one pending word.
  - in_ready stays low while that word is pending.
- out_data, out_valid and out_phase are decoded from registered state and P1/P0 only. There are no combinational paths from in_* or out_ready to out_*.
- in_ready depends combinationally only on en and the r_valid register.

## Configuration
- Q_8_41_INTERP_UNDERRUN_EN defined:
  - adds the underrun_cnt port, an 8-bit saturating counter;
  - it increments in each cycle with en=1, out_ready=1 and out_valid=0;
  - it saturates at 255 and is cleared only by rst.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset mid-pair: load 0xA55A (W=8) and handshake the upper sample, then assert rst for 1 cycle. Required: out_valid=0, out_data=0 and in_ready=0 during the rst cycle. Required after release: S_EMPTY, and no lower sample 0x5A is ever emitted.
- Single word, ready sink: in_data=0x1234 accepted in cycle 0. Required: cycle 2 gives out_data=0x12 with out_phase=0; cycle 3 gives 0x34 with phase 1; cycle 4 gives out_valid=0.
- Streaming: words 0x0102, 0x0304 and 0x0506 are offered continuously with out_ready=1. Required: the output sequence is 01,02,03,04,05,06 on consecutive cycles with no out_valid gap, and in_ready toggles every other cycle.
- Backpressure: word 0xBEEF, with out_ready=0 for 5 cycles during S_FIRST. Required: 0xBE held stable for all 5 cycles. A second word offered meanwhile is latched into R0, and in_ready stays 0. Both words then complete in order: BE, EF, then the second word's two halves.
- en gating: a word is accepted, then en=0 with in_valid=1 held. Required: both samples of the accepted word are emitted, in_ready stays 0, and no further word is accepted until en=1.
- With Q_8_41_INTERP_UNDERRUN_EN: hold en=1, out_ready=1 and no input for 300 cycles after reset. Required: underrun_cnt saturates at 255 and stays there.
